// File: rtl/barrett_reduction.sv
// barrett_reduction: pipelined Barrett reducer, R = C mod Q.
// Input capture, quotient estimate, remainder, two conditional subtracts.
module barrett_reduction #(
  parameter int unsigned Q  = 32'd8380417,
  parameter int unsigned K  = 32'd64,
  parameter logic [41:0] MU = 42'((65'd1 << K) / 65'(Q))
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] C,
  output logic [31:0] R
);

  localparam logic [24:0] Q25 = 25'(Q);

  logic [63:0] c0;
  logic [41:0] qhat1;
  logic [24:0] c1;
  logic [24:0] r2;
  logic [22:0] r3;

  logic [41:0] qhat_d;
  logic [24:0] r_d;
  logic [24:0] s1;
  logic [24:0] s2;

  // Quotient estimate: top bits of C * MU.
  assign qhat_d = 42'((106'(c0) * 106'(MU)) >> K);

  // Remainder is below 3Q, so only the low 25 bits matter.
  assign r_d = c1 - 25'(67'(qhat1) * 67'(Q));

  // Two conditional subtractions bring r into [0, Q-1].
  always_comb begin
    s1 = r2;
    if (r2 >= Q25) s1 = r2 - Q25;
    s2 = s1;
    if (s1 >= Q25) s2 = s1 - Q25;
  end

  // Capture the raw operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c0 <= '0;
    else        c0 <= C;
  end

  // Register the quotient estimate and the low operand bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qhat1 <= '0;
      c1    <= '0;
    end else begin
      qhat1 <= qhat_d;
      c1    <= c0[24:0];
    end
  end

  // Register the unreduced remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r2 <= '0;
    else        r2 <= r_d;
  end

  // Register the canonical result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r3 <= '0;
    else        r3 <= 23'(s2);
  end

  assign R = {9'b0, r3};

endmodule

// File: tb/tb_barrett_reduction.sv
// tb_barrett_reduction: scoreboard bench for barrett_reduction.
// Directed vectors, random stream, and mid-stream reset.
module tb_barrett_reduction;

  localparam logic [31:0] QM = 32'd8380417;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] C     = 64'd0;
  logic [31:0] R;

  barrett_reduction dut (
    .clk   (clk),
    .rst_n (rst_n),
    .C     (C),
    .R     (R)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  logic [3:0]  tok = 4'd0;
  int          sent_cnt = 0;
  int          seen_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  // Token pipe mirrors which sampled cycles carry a scoreboard entry.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok = 4'd0;
      seen_cnt = sent_cnt;
      exp_q.delete();
    end else begin
      tok = {tok[2:0], sent_cnt != seen_cnt};
      seen_cnt = sent_cnt;
    end
  end

  // Monitor: compare on the falling edge.
  always @(negedge clk) begin
    logic [31:0] e;
    tests++;
    if (R >= QM) begin
      fails++;
      $display("FAIL range: R=%0d not below %0d", R, QM);
    end
    tests++;
    if (R[31:23] != 9'd0) begin
      fails++;
      $display("FAIL upper: R[31:23]=%0h required 0", R[31:23]);
    end
    if (tok[3]) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL underflow: R=%0d with empty scoreboard", R);
      end else begin
        e = exp_q.pop_front();
        if (R !== e) begin
          fails++;
          $display("FAIL result: R=%0d required %0d", R, e);
        end
      end
    end else begin
      tests++;
      if (R !== 32'd0) begin
        fails++;
        $display("FAIL idle: R=%0d required 0", R);
      end
    end
  end

  task automatic send(input logic [63:0] c, input logic [31:0] e);
    C = c;
    exp_q.push_back(e);
    sent_cnt++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    C = 64'd0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [63:0] rc;
    rst_n = 1'b0;
    C = 64'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    send(64'd8380417, 32'd0);
    send(64'd8380418, 32'd1);
    send(64'd8380416, 32'd8380416);
    send(64'd16760833, 32'd8380416);
    send(64'd16760834, 32'd0);
    send(64'd25141250, 32'd8380416);
    send(64'd10, 32'd10);
    send(64'd1, 32'd1);
    send(64'd0, 32'd0);
    send(64'hAFFF_FFFF_FFFF, 32'd2230252);
    send(64'hFFFF_FFFF_FFFF_FFFF, 32'd2365950);
    idle(5);

    for (int i = 0; i < 10000; i++) begin
      rc = {$urandom, $urandom};
      send(rc, 32'(rc % 64'(QM)));
    end
    idle(5);

    send(64'd100, 32'd100);
    send(64'd200, 32'd200);
    send(64'd300, 32'd300);
    send(64'd400, 32'd400);
    C = 64'd0;
    #1;
    tests++;
    if (R !== 32'd100) begin
      fails++;
      $display("FAIL pre_pulse: R=%0d required 100", R);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (R !== 32'd0) begin
      fails++;
      $display("FAIL async_rst: R=%0d required 0", R);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);

    send(64'd25141250, 32'd8380416);
    send(64'd99, 32'd99);
    send(64'd16760834, 32'd0);
    send(64'd8380419, 32'd2);
    idle(6);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
